// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact fill count, threshold flags, synchronous flush and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read with one cycle of latency.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          write_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          read_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(DEPTH):0]        fill_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AE_THRESH < 0 ||
      AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [CNT_W-1:0]      fill_next;
  logic                  wr_acc, rd_acc, overflow_next, underflow_next;

  // Flags decode straight from the registered count, so they change on the same edge as fill_count.
  assign full         = (fill_count == FULL_CNT);
  assign empty        = (fill_count == '0);
  assign almost_full  = (fill_count >= AF_CNT);
  assign almost_empty = (fill_count <= AE_CNT);

  // NOTE: combinational next-state logic uses blocking '=' with every output defaulted first,
  // so no latch is inferred; the registers below use non-blocking '<=' only.
  always_comb begin
    wr_acc         = 1'b0;
    rd_acc         = 1'b0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    fill_next      = fill_count;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      fill_next   = '0;
    end else begin
      wr_acc         = write_en & ~full;
      rd_acc         = read_en & ~empty;
      overflow_next  = write_en & full;
      underflow_next = read_en & empty;
      if (wr_acc) wr_ptr_next = wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr_next = rd_ptr + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   fill_next = fill_count + CNT_W'(1);
        2'b01:   fill_next = fill_count - CNT_W'(1);
        default: fill_next = fill_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      fill_count <= fill_next;
      overflow   <= overflow_next;
      underflow  <= underflow_next;
    end
  end

  // NOTE: the storage array has no reset; stale words are never visible because
  // the pointers and fill count gate every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented as soon as it is stored; read_en acknowledges and pops it.
  assign data_out   = empty ? '0 : mem[rd_ptr];
  assign data_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) data_q <= mem[rd_ptr];
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_WIDTH=8, DEPTH=16, AF=12, AE=2).
// Read-side expectations follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset_n, clear, write_en, read_en;
  logic [7:0] data_in, data_out;
  logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] fill_count;

  int         n_checks = 0;
  int         n_bad = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_word;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out), .data_valid(data_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fill_count(fill_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs changed 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty_state(input string tag);
    check({tag, "_fill"}, 32'(fill_count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_afull"}, 32'(almost_full), 32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
  endtask

  // Write one word into an empty FIFO and read it back in the current mode.
  task automatic write_then_read(input string tag, input logic [7:0] word);
    write_en = 1'b1; data_in = word;
    tick();
    write_en = 1'b0;
    check({tag, "_fill1"}, 32'(fill_count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    check({tag, "_fwft_data"}, 32'(data_out), 32'(word));
    check({tag, "_fwft_valid"}, 32'(data_valid), 32'd1);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check({tag, "_fwft_valid_drop"}, 32'(data_valid), 32'd0);
`else
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check({tag, "_data"}, 32'(data_out), 32'(word));
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
`endif
    check({tag, "_empty_after"}, 32'(empty), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = 8'h00;
    #12;
    check_empty_state("reset");
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_udf", 32'(underflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // Fill with 0x01..0x10, then one extra write that must be dropped.
    for (int i = 1; i <= 16; i++) begin
      write_en = 1'b1; data_in = 8'(i);
      tick();
      check("fill_count", 32'(fill_count), 32'(i));
      check("fill_afull", 32'(almost_full), 32'(i >= 12));
      check("fill_aempty", 32'(almost_empty), 32'(i <= 2));
      check("fill_full", 32'(full), 32'(i == 16));
      check("fill_ovf", 32'(overflow), 32'd0);
    end
    data_in = 8'h99;
    tick();
    write_en = 1'b0;
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fill_count), 32'd16);
    tick();
    check("ovf_once", 32'(overflow), 32'd0);

    // Drain 17 times; the last read is an underflow.
    for (int i = 1; i <= 17; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("drain_fwft_valid", 32'(data_valid), 32'(i <= 16));
      check("drain_fwft_data", 32'(data_out), (i <= 16) ? 32'(i) : 32'd0);
`endif
      read_en = 1'b1;
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_valid", 32'(data_valid), 32'(i <= 16));
      check("drain_data", 32'(data_out), (i <= 16) ? 32'(i) : 32'h10);
`endif
      check("drain_count", 32'(fill_count), (i <= 16) ? 32'(16 - i) : 32'd0);
      check("drain_empty", 32'(empty), 32'(i >= 16));
      check("drain_udf", 32'(underflow), 32'(i == 17));
    end
    read_en = 1'b0;
    tick();
    check("udf_once", 32'(underflow), 32'd0);

    // Hold five entries and stream 40 simultaneous read/write cycles through the wrap.
    for (int i = 0; i < 5; i++) begin
      write_en = 1'b1; data_in = 8'(8'h30 + i);
      model_q.push_back(data_in);
      tick();
    end
    check("stream_start_count", 32'(fill_count), 32'd5);
    for (int c = 0; c < 40; c++) begin
      write_en = 1'b1; read_en = 1'b1; data_in = 8'(8'h40 + c);
      exp_word = model_q.pop_front();
      model_q.push_back(data_in);
`ifdef SYNC_FIFO_FWFT_EN
      check("stream_fwft_data", 32'(data_out), 32'(exp_word));
`endif
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      check("stream_data", 32'(data_out), 32'(exp_word));
      check("stream_valid", 32'(data_valid), 32'd1);
`endif
      check("stream_count", 32'(fill_count), 32'd5);
      check("stream_ovf", 32'(overflow), 32'd0);
      check("stream_udf", 32'(underflow), 32'd0);
    end
    write_en = 1'b0; read_en = 1'b0;

    // Flush, refill nine words, then flush again with a concurrent write.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_empty_state("clear0");
    for (int i = 0; i < 9; i++) begin
      write_en = 1'b1; data_in = 8'(8'h50 + i);
      tick();
    end
    check("nine_count", 32'(fill_count), 32'd9);
    clear = 1'b1; write_en = 1'b1; data_in = 8'hEE;
    tick();
    clear = 1'b0; write_en = 1'b0;
    check_empty_state("clear1");
    check("clear_ovf", 32'(overflow), 32'd0);
    tick();
    check("clear_stays", 32'(fill_count), 32'd0);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check("clear_write_dropped", 32'(underflow), 32'd1);
    check("clear_no_valid", 32'(data_valid), 32'd0);

    // Asynchronous reset in the middle of a write burst after a word has been read out.
    write_then_read("pre_rst", 8'h3C);
    write_en = 1'b1; data_in = 8'h61;
    tick();
    data_in = 8'h62;
    tick();
    check("burst_count", 32'(fill_count), 32'd2);
    #3;
    reset_n = 1'b0; write_en = 1'b0;
    #1;
    check_empty_state("async_rst");
    check("async_rst_data", 32'(data_out), 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    check("post_rst_count", 32'(fill_count), 32'd0);
    write_then_read("post_rst", 8'hA5);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
